imem_load_ctrl: RTL and testbench
=================================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit instruction words (word index = 8 bits).
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port cpu_pc, input, 32: CPU fetch byte address.
REQ-005 SHALL have port cpu_instr, output, 32: instruction returned to CPU.
REQ-006 SHALL have port cpu_hold, output, 1: CPU must not advance PC or commit state while high.
REQ-007 SHALL have port cpu_pc_clr, output, 1: one-cycle request to force PC to 0.
REQ-008 SHALL have port load_start, input, 1: begin a program load.
REQ-009 SHALL have port load_len, input, 9: word count; sampled only on an accepted load_start.
REQ-010 SHALL have port load_abort, input, 1: terminate an in-progress load.
REQ-011 SHALL have port load_valid, input, 1: loader byte valid.
REQ-012 SHALL have port load_byte, input, 8: loader byte, MSB-first within each word.
REQ-013 SHALL have port load_ready, output, 1: controller accepts byte this cycle.
REQ-014 SHALL have port load_done, output, 1: one-cycle pulse, load finished or aborted.
REQ-015 SHALL have ports mem_addr (output, 8), mem_wdata (output, 32), mem_we (output, 1), mem_rdata (input, 32): word-indexed memory port with combinational read and synchronous write.

Function
REQ-016 SHALL implement states RUN, LOAD, WRITE, FLUSH.
REQ-017 In RUN: mem_addr = cpu_pc[9:2]; cpu_instr = mem_rdata when cpu_pc[31:10]==0, else 32'h00000000; cpu_pc[1:0] ignored; cpu_hold=0; mem_we=0; load_ready=0.
REQ-018 RUN->LOAD on load_start=1; word pointer cleared to 0; byte counter cleared to 0; length latched as min(load_len, 256).
REQ-019 A latched length of 0 SHALL make RUN->FLUSH directly, with no memory write.
REQ-020 In LOAD: load_ready=1; a byte is accepted when load_valid&&load_ready and shifted into the assembly register as the least significant byte after shifting left by 8.
REQ-021 On the 4th accepted byte of a word, LOAD->WRITE.
REQ-022 In WRITE: load_ready=0; mem_we=1 for exactly one cycle; mem_addr = word pointer; mem_wdata = assembled word.
REQ-023 After WRITE, the word pointer SHALL increment; if the new pointer equals the latched length, WRITE->FLUSH, otherwise WRITE->LOAD.
REQ-024 In FLUSH (one cycle): cpu_pc_clr=1 and load_done=1; then FLUSH->RUN.
REQ-025 In LOAD, WRITE and FLUSH: cpu_hold=1 and cpu_instr=32'h00000000.
REQ-026 load_abort in LOAD SHALL go to FLUSH and discard partial bytes.
REQ-027 load_abort in WRITE SHALL complete that write, then go to FLUSH.
REQ-028 load_abort has no effect in RUN and FLUSH.
REQ-029 load_start SHALL be ignored outside RUN.
REQ-030 If load_start and load_abort are both high in RUN, start SHALL win.
REQ-031 The word pointer SHALL be 9 bits; a length of 256 writes indices 0..255 with no wrap.
REQ-032 Memory write latency: a byte accepted in cycle N as the 4th byte produces mem_we in cycle N+1.
REQ-033 Steady-state throughput: 1 word per 5 cycles with load_valid held high.

Reset
REQ-034 While reset=1: state=RUN; pointer, byte counter, assembly register and latched length = 0; cpu_hold=0, cpu_pc_clr=0, load_ready=0, load_done=0, mem_we=0.
REQ-035 Reset mid-load SHALL abandon the load with no load_done pulse; memory words already written are retained.

Verification
REQ-036 RUN, cpu_pc=0x24, mem_rdata=0x08100003 -> mem_addr=9, cpu_instr=0x08100003, cpu_hold=0; cpu_pc=0x400 -> cpu_instr=0.
REQ-037 load_start with load_len=2, bytes 20 04 00 00 20 05 00 20, load_valid held high -> mem_we at idx 0 with 0x20040000, then at idx 1 with 0x20050020; FLUSH with cpu_pc_clr=1 and load_done=1; back in RUN 12 cycles after start.
REQ-038 load_len=0 -> FLUSH the next cycle; no mem_we; load_done pulse.
REQ-039 load_len=300, 1024 bytes supplied -> exactly 256 writes, last at idx 255; no write to idx 0 after idx 255.
REQ-040 Abort after 2 bytes of word 1 -> no write of word 1; load_done pulse; RUN; word 0 retained.
REQ-041 Reset asserted during WRITE -> mem_we drops immediately; RUN; no load_done; load_start during LOAD ignored.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: serves CPU fetches in normal operation and assembles
// MSB-first loader bytes into 32-bit words written into the instruction memory.
module imem_load_ctrl #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_pc,
  output logic [31:0] cpu_instr,
  output logic        cpu_hold,
  output logic        cpu_pc_clr,
  input  logic        load_start,
  input  logic [8:0]  load_len,
  input  logic        load_abort,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_ready,
  output logic        load_done,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StRun, StLoad, StWrite, StFlush} state_e;

  localparam logic [8:0] MaxLen = 9'(DEPTH);

  state_e      state_q, state_d;
  logic [8:0]  ptr_q, ptr_d;
  logic [8:0]  len_q, len_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [8:0]  len_clamped;

  // Byte offset bits of the fetch address are not needed for word-indexed memory.
  logic unused_pc;
  assign unused_pc = ^cpu_pc[1:0];

  assign len_clamped = (load_len > MaxLen) ? MaxLen : load_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      ptr_q   <= 9'd0;
      len_q   <= 9'd0;
      cnt_q   <= 2'd0;
      asm_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    cpu_instr  = 32'd0;
    cpu_hold   = 1'b1;
    cpu_pc_clr = 1'b0;
    load_ready = 1'b0;
    load_done  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = ptr_q[7:0];
    mem_wdata  = asm_q;

    case (state_q)
      StRun: begin
        cpu_hold = 1'b0;
        mem_addr = cpu_pc[9:2];
        // Fetches beyond the 1 KiB instruction window return a zero word.
        if (cpu_pc[31:10] == 22'd0) begin
          cpu_instr = mem_rdata;
        end
        if (load_start) begin
          ptr_d   = 9'd0;
          cnt_d   = 2'd0;
          asm_d   = 32'd0;
          len_d   = len_clamped;
          state_d = (len_clamped == 9'd0) ? StFlush : StLoad;
        end
      end
      StLoad: begin
        load_ready = 1'b1;
        if (load_abort) begin
          cnt_d   = 2'd0;
          asm_d   = 32'd0;
          state_d = StFlush;
        end else if (load_valid) begin
          asm_d = {asm_q[23:0], load_byte};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 9'd1;
        if (load_abort || (ptr_d == len_q)) begin
          state_d = StFlush;
        end else begin
          state_d = StLoad;
        end
      end
      StFlush: begin
        cpu_pc_clr = 1'b1;
        load_done  = 1'b1;
        state_d    = StRun;
      end
      default: state_d = StRun;
    endcase
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a behavioural memory and a write scoreboard.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_instr;
  logic        cpu_hold;
  logic        cpu_pc_clr;
  logic        load_start;
  logic [8:0]  load_len;
  logic        load_abort;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        load_done;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  logic [39:0] exp_q [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int wr_cnt = 0;
  int last_addr = -1;

  imem_load_ctrl #(.DEPTH(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_pc     (cpu_pc),
    .cpu_instr  (cpu_instr),
    .cpu_hold   (cpu_hold),
    .cpu_pc_clr (cpu_pc_clr),
    .load_start (load_start),
    .load_len   (load_len),
    .load_abort (load_abort),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .load_done  (load_done),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Write monitor: every observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [39:0] e;
    if (!reset) begin
      if (mem_we) begin
        wr_cnt++;
        last_addr = int'(mem_addr);
        chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(e[39:32]));
          chk("write_data", mem_wdata, e[31:0]);
        end
      end
      if (load_done || cpu_pc_clr) begin
        done_cnt++;
        done_cyc = cyc;
        chk("pc_clr_with_done", 32'(cpu_pc_clr), 32'(load_done));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    load_valid = 1'b1;
    load_byte  = b;
    while (!load_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("ready_wait", 32'(load_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic start_load(input logic [8:0] len, output int s);
    load_start = 1'b1;
    load_len   = len;
    s          = cyc;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int g = 0;
    #1;
    while (done_cnt == prev && g < 2000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("done_seen", 32'(done_cnt), 32'(prev + 1));
  endtask

  initial begin
    int s;
    int prev;
    int wr_base;
    logic [31:0] w;
    logic [31:0] old1;
    logic [31:0] words [256];

    foreach (mem[i]) mem[i] = 32'hDEAD0000 | 32'(i);
    mem[9]     = 32'h08100003;
    reset      = 1'b1;
    cpu_pc     = 32'd0;
    load_start = 1'b0;
    load_len   = 9'd0;
    load_abort = 1'b0;
    load_valid = 1'b0;
    load_byte  = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_pc_clr", 32'(cpu_pc_clr), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch path
    cpu_pc = 32'h24;
    #1;
    chk("run_addr", 32'(mem_addr), 32'd9);
    chk("run_instr", cpu_instr, 32'h08100003);
    chk("run_hold", 32'(cpu_hold), 32'd0);
    cpu_pc = 32'h27;
    #1;
    chk("run_lowbits_ignored", cpu_instr, 32'h08100003);
    cpu_pc = 32'h400;
    #1;
    chk("run_out_of_range", cpu_instr, 32'd0);
    cpu_pc = 32'h24;
    @(negedge clk);

    // Two-word load with timing
    push_wr(8'd0, 32'h20040000);
    push_wr(8'd1, 32'h20050020);
    prev = done_cnt;
    start_load(9'd2, s);
    chk("load_hold", 32'(cpu_hold), 32'd1);
    chk("load_instr_zero", cpu_instr, 32'd0);
    send_word(32'h20040000);
    send_word(32'h20050020);
    load_valid = 1'b0;
    wait_done(prev);
    chk("flush_cycle", 32'(done_cyc), 32'(s + 11));
    @(negedge clk);
    chk("run_after_load", 32'(cpu_hold), 32'd0);
    chk("mem0", mem[0], 32'h20040000);
    chk("mem1", mem[1], 32'h20050020);

    // Zero-length load
    prev = done_cnt;
    start_load(9'd0, s);
    chk("zero_len_done", 32'(load_done), 32'd1);
    chk("zero_len_hold", 32'(cpu_hold), 32'd1);
    wait_done(prev);
    chk("zero_len_cycle", 32'(done_cyc), 32'(s + 1));
    @(negedge clk);
    chk("zero_len_run", 32'(cpu_hold), 32'd0);

    // Over-length load clamps to 256 words
    for (int i = 0; i < 256; i++) begin
      words[i] = $urandom();
      push_wr(8'(i), words[i]);
    end
    wr_base = wr_cnt;
    prev    = done_cnt;
    start_load(9'd300, s);
    for (int i = 0; i < 256; i++) send_word(words[i]);
    wait_done(prev);
    load_valid = 1'b1;
    repeat (10) @(negedge clk);
    load_valid = 1'b0;
    chk("max_write_count", 32'(wr_cnt - wr_base), 32'd256);
    chk("max_last_addr", 32'(last_addr), 32'd255);
    chk("max_mem255", mem[255], words[255]);

    // Abort mid-word
    old1 = mem[1];
    push_wr(8'd0, 32'hA5A55A5A);
    prev = done_cnt;
    start_load(9'd3, s);
    send_word(32'hA5A55A5A);
    send_byte(8'h11);
    send_byte(8'h22);
    load_valid = 1'b0;
    load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0;
    wait_done(prev);
    @(negedge clk);
    chk("abort_run", 32'(cpu_hold), 32'd0);
    chk("abort_mem0", mem[0], 32'hA5A55A5A);
    chk("abort_mem1_kept", mem[1], old1);

    // Abort during a write completes the write
    push_wr(8'd0, 32'hC0FFEE01);
    prev = done_cnt;
    start_load(9'd3, s);
    send_word(32'hC0FFEE01);
    load_valid = 1'b0;
    load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0;
    wait_done(prev);
    @(negedge clk);
    chk("wr_abort_mem0", mem[0], 32'hC0FFEE01);
    chk("wr_abort_mem1_kept", mem[1], old1);

    // Start wins over abort in RUN
    push_wr(8'd0, 32'h13579BDF);
    prev       = done_cnt;
    load_abort = 1'b1;
    start_load(9'd1, s);
    load_abort = 1'b0;
    chk("start_wins_ready", 32'(load_ready), 32'd1);
    send_word(32'h13579BDF);
    load_valid = 1'b0;
    wait_done(prev);
    @(negedge clk);
    chk("start_wins_mem0", mem[0], 32'h13579BDF);

    // Start ignored during LOAD, then reset during WRITE
    push_wr(8'd0, 32'h0BADF00D);
    prev = done_cnt;
    start_load(9'd2, s);
    send_byte(8'h0B);
    load_start = 1'b1;
    load_len   = 9'd0;
    send_byte(8'hAD);
    load_start = 1'b0;
    send_byte(8'hF0);
    send_byte(8'h0D);
    send_byte(8'h77);
    send_byte(8'h66);
    send_byte(8'h55);
    load_valid = 1'b1;
    load_byte  = 8'h44;
    @(posedge clk);
    #1;
    chk("write_before_reset", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_we_drop", 32'(mem_we), 32'd0);
    chk("reset_hold", 32'(cpu_hold), 32'd0);
    chk("reset_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_no_done", 32'(done_cnt), 32'(prev));
    chk("reset_mem0_kept", mem[0], 32'h0BADF00D);
    chk("reset_mem1_kept", mem[1], old1);
    chk("reset_run", 32'(cpu_hold), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
